// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle HI/LO multiply/divide sequencer with md-hazard stall request.
// Define MD_CANCEL_EN to add a cancel input that aborts an in-flight operation without commit.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES - 1);
    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] tmp_hi, tmp_lo, tmp_hi_nx, tmp_lo_nx, hi_nx, lo_nx;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_abs, b_abs, b_safe, rt_safe, q_abs, r_abs, q_s, r_s, q_u, r_u;
    logic        div_zero, kill;
`ifdef MD_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif
    assign prod_s   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u   = {32'b0, rs_val} * {32'b0, rt_val};
    // Signed divide works on magnitudes so INT_MIN / -1 wraps to 0x80000000 cleanly.
    assign div_zero = rt_val == 32'd0;
    assign a_abs    = rs_val[31] ? -rs_val : rs_val;
    assign b_abs    = rt_val[31] ? -rt_val : rt_val;
    assign b_safe   = div_zero ? 32'd1 : b_abs;
    assign rt_safe  = div_zero ? 32'd1 : rt_val;
    assign q_abs    = a_abs / b_safe;
    assign r_abs    = a_abs % b_safe;
    assign q_s      = (rs_val[31] ^ rt_val[31]) ? -q_abs : q_abs;
    assign r_s      = rs_val[31] ? -r_abs : r_abs;
    assign q_u      = rs_val / rt_safe;
    assign r_u      = rs_val % rt_safe;
    assign busy     = state == RUN;
    assign stall_md = md_use_D & (busy | (start & ~md_op[2]));
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        hi_nx     = hi;
        lo_nx     = lo;
        tmp_hi_nx = tmp_hi;
        tmp_lo_nx = tmp_lo;
        if (state == IDLE) begin
            if (start) begin
                case (md_op)
                    3'd0, 3'd1: begin
                        {tmp_hi_nx, tmp_lo_nx} = md_op[0] ? prod_u : prod_s;
                        cnt_nx   = MULT_N;
                        state_nx = RUN;
                    end
                    3'd2, 3'd3: begin
                        tmp_hi_nx = div_zero ? hi : (md_op[0] ? r_u : r_s);
                        tmp_lo_nx = div_zero ? lo : (md_op[0] ? q_u : q_s);
                        cnt_nx    = DIV_N;
                        state_nx  = RUN;
                    end
                    3'd4:    hi_nx = rs_val;
                    3'd5:    lo_nx = rs_val;
                    default: ;
                endcase
            end
        end else if (kill) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
        end else if (cnt == 4'd0) begin
            hi_nx    = tmp_hi;
            lo_nx    = tmp_lo;
            state_nx = IDLE;
        end else begin
            cnt_nx = cnt - 4'd1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            hi     <= hi_nx;
            lo     <= lo_nx;
            tmp_hi <= tmp_hi_nx;
            tmp_lo <= tmp_lo_nx;
        end
    end
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: scoreboard bench for md_unit_ctrl; commits are checked by a monitor on busy falling.
module tb_md_unit_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd7;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        md_use_D = 1'b0;
    logic        busy, stall_md;
    logic [31:0] hi, lo;
`ifdef MD_CANCEL_EN
    logic        cancel = 1'b0;
`endif
    int cmp = 0;
    int mism = 0;
    logic [63:0] sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit quiet = 1'b0;
    bit prev_b = 1'b0;

    md_unit_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use_D(md_use_D),
`ifdef MD_CANCEL_EN
        .cancel(cancel),
`endif
        .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp++;
        if (!ok) begin
            mism++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every busy falling edge outside reset is a commit and must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset) prev_b = 1'b0;
        else begin
            if (prev_b && !busy && !quiet) begin
                if (sb.size() == 0) chk(1'b0, "unexpected_commit", {hi, lo}, 64'd0);
                else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    chk({hi, lo} == e, "commit_hilo", {hi, lo}, e);
                end
            end
            prev_b = busy;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int n,
                         input bit use_d, input bit inj);
        int nb = 0;
        int bad = 0;
        sb.push_back({eh, el});
        md_use_D = use_d; start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        #1;
        if (use_d) chk(stall_md == 1'b1, "stall_issue", 64'(stall_md), 64'd1);
        @(posedge clk);
        #1 start = 1'b0; md_op = 3'd7;
        @(negedge clk);
        while (busy && nb < 40) begin
            nb++;
            if (use_d && !stall_md) bad++;
            if (inj && nb == 3) chk(hi == m_hi, "ignore_mthi", 64'(hi), 64'(m_hi));
            if (inj && nb == 2) begin
                start = 1'b1; md_op = 3'd4; rs_val = 32'hABCD;
            end else begin
                start = 1'b0; md_op = 3'd7;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk(nb == n, "busy_len", 64'(nb), 64'(n));
        if (use_d) begin
            chk(bad == 0, "stall_busy", 64'(bad), 64'd0);
            chk(stall_md == 1'b0, "stall_after", 64'(stall_md), 64'd0);
        end
        md_use_D = 1'b0;
        m_hi = eh; m_lo = el;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        start = 1'b1; md_op = op; rs_val = v;
        @(posedge clk);
        #1 start = 1'b0; md_op = 3'd7;
        @(negedge clk);
        if (op == 3'd4) m_hi = v; else m_lo = v;
        chk(busy == 1'b0, "mt_busy", 64'(busy), 64'd0);
        chk({hi, lo} == {m_hi, m_lo}, "mt_hilo", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk(busy == 1'b0, "reset_busy", 64'(busy), 64'd0);
        chk({hi, lo} == 64'd0, "reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        issue(3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 1'b0, 1'b0);
        issue(3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 1'b0, 1'b0);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0, 1'b0);
        mt(3'd4, 32'h11);
        mt(3'd5, 32'h22);
        issue(3'd3, 32'd5, 32'd0, 32'h11, 32'h22, 10, 1'b0, 1'b0);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10, 1'b0, 1'b0);
        issue(3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0, 1'b0);
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 10, 1'b0, 1'b0);
        issue(3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b1, 1'b1);
        // Reset in busy cycle 3 of a divide: no commit may follow.
        start = 1'b1; md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk);
        #1 start = 1'b0; md_op = 3'd7;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
        chk({hi, lo} == 64'd0, "rst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (12) @(negedge clk);
        chk(busy == 1'b0, "rst_later_busy", 64'(busy), 64'd0);
        chk({hi, lo} == 64'd0, "rst_later_hilo", {hi, lo}, 64'd0);
`ifdef MD_CANCEL_EN
        mt(3'd4, 32'h66);
        mt(3'd5, 32'h55);
        quiet = 1'b1;
        start = 1'b1; md_op = 3'd0; rs_val = 32'd3; rt_val = 32'd3;
        @(posedge clk);
        #1 start = 1'b0; md_op = 3'd7;
        repeat (2) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk(busy == 1'b0, "cancel_busy", 64'(busy), 64'd0);
        chk({hi, lo} == {32'h66, 32'h55}, "cancel_hilo", {hi, lo}, {32'h66, 32'h55});
        repeat (8) @(negedge clk);
        chk({hi, lo} == {32'h66, 32'h55}, "cancel_later", {hi, lo}, {32'h66, 32'h55});
        quiet = 1'b0;
`endif
        @(negedge clk);
        chk(sb.size() == 0, "sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Sequencer for the shared HI/LO multiply/divide resource in the E stage of the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E and holds the operation busy for a fixed multi-cycle latency.
- Commits HI/LO at the end of that latency and raises the stall request used by the hazard unit for any md-class instruction waiting in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  E-stage md op valid this cycle
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 no-op
- rs_val  input  32  forwarded rs operand (E stage)
- rt_val  input  32  forwarded rt operand (E stage)
- md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  output  1  multi-cycle operation in flight
- stall_md  output  1  md_use_D & (busy | (start & md_op<4)); combinational
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, cnt=0, busy=0, hi=0, lo=0, result temporaries=0. Reset mid-operation abandons the operation with no commit.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start=1, md_op MULT/MULTU:
  - On the edge, compute the 64-bit product (signed or unsigned) into tmp_hi:tmp_lo.
  - cnt=MULT_CYCLES-1, go to RUN.
- IDLE, start=1, md_op DIV/DIVU: on the edge, compute into tmp_lo and tmp_hi, then cnt=DIV_CYCLES-1, go to RUN.
  - tmp_lo=quotient, tmp_hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (rt_val==0): temporaries are loaded with the current hi/lo, so HI/LO are unchanged after commit. busy still lasts DIV_CYCLES.
- IDLE, start=1, md_op MTHI/MTLO: hi (or lo) <= rs_val on the edge. No busy; stays IDLE.
- IDLE, start=1, md_op 6/7: ignored.
- RUN: decrement cnt each edge. On the edge where cnt==0: hi<=tmp_hi, lo<=tmp_lo, go to IDLE.
- Timing contract: busy is high for exactly N cycles after the issue edge (N=MULT_CYCLES or DIV_CYCLES). New HI/LO are visible in the first cycle busy is low.
- start while busy: ignored completely, including MTHI/MTLO; HI/LO and the counter are unaffected. The hazard unit prevents this via stall_md; the bench checks the ignore.
- hi/lo outputs always reflect committed registers only; temporaries are never forwarded.
- Back-to-back: start in the cycle busy falls is accepted normally. Zero idle gap is required.
- stall_md covers the issue cycle itself (start with md_op<4), so a following mfhi in D stalls immediately.

Optional Feature:
- Macro MD_CANCEL_EN.
- Defined: adds input port cancel (1 bit). cancel=1 sampled at an edge while in RUN returns to IDLE, cnt=0, with no HI/LO commit. cancel=1 in IDLE is ignored. cancel has priority over the cnt==0 commit on the same edge.
- Undefined: no cancel port; every accepted multi-cycle operation always commits.

Test Plan:
- mult: rs=0xFFFFFFFF, rt=2 -> busy exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu: rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- div: rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu by zero with prior hi=0x11, lo=0x22 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- Stall and ignore: mult issued with md_use_D=1 -> stall_md=1 in the issue cycle and all 5 busy cycles, 0 after. MTHI 0xABCD with start=1 during busy -> hi unchanged.
- Reset and cancel:
  - reset pulled low at busy cycle 3 of div -> busy=0, hi=lo=0 immediately, with no later commit.
  - With MD_CANCEL_EN, cancel at busy cycle 2 of mult -> busy=0 next cycle, HI/LO keep their old values.
